ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 34 +++
 rtl/ram_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports plus the single-port RAM connection.
// The arbiter uses the slave modport; requesters and the RAM model use the master modport.
interface ram_port_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 41
) ();
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, din0, din1, ram_do,
        output ack0, ack1, dout0, dout1, ram_en, ram_we, ram_addr, ram_di
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, din0, din1, ram_do,
        input  ack0, ack1, dout0, dout1, ram_en, ram_we, ram_addr, ram_di
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of one synchronous single-port RAM: IDLE -> ACCESS -> DONE.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 wins ties.
module ram_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 41
) (
    input  logic               clk,
    input  logic               rst,
    ram_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_reg, state_next;
    logic          winner_reg, winner_next;
    logic          we_reg, we_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] din_reg, din_next;
    logic          grant_id;
    logic          access;
    logic          done;
    logic [1:0]    ack_vec;
    logic [DW-1:0] dout_vec [2];

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic prio_reg, prio_next;

    // Pointer only matters on a tie; a sole requester always wins.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            grant_id = prio_reg;
        end else begin
            grant_id = !bus.req0;
        end
    end
`else
    always_comb begin
        grant_id = !bus.req0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            winner_reg <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            din_reg    <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            prio_reg   <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            din_reg    <= din_next;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            prio_reg   <= prio_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        din_next    = din_reg;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        prio_next   = prio_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_next  = ACCESS;
                    winner_next = grant_id;
                    we_next     = grant_id ? bus.we1   : bus.we0;
                    addr_next   = grant_id ? bus.addr1 : bus.addr0;
                    din_next    = grant_id ? bus.din1  : bus.din0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    prio_next   = !grant_id;
`endif
                end
            end
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign access = (state_reg == ACCESS);
    assign done   = (state_reg == DONE);

    // RAM pins are quiet (all zero) outside the single ACCESS cycle.
    assign bus.ram_en   = access;
    assign bus.ram_we   = access && we_reg;
    assign bus.ram_addr = access ? addr_reg : '0;
    assign bus.ram_di   = access ? din_reg  : '0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);
            assign ack_vec[gi]  = done && (winner_reg == PORT_ID);
            assign dout_vec[gi] = ack_vec[gi] ? bus.ram_do : '0;
        end
    endgenerate

    assign bus.ack0  = ack_vec[0];
    assign bus.ack1  = ack_vec[1];
    assign bus.dout0 = dout_vec[0];
    assign bus.dout1 = dout_vec[1];
endmodule
